seq_mult_param: RTL and testbench

Parametrised sequential shift-add multiplier with a start/done handshake and a selectable signed (two's-complement) or unsigned mode. It computes one partial product per clock and needs no combinational array multiplier. It replaces the fixed 4x4 multiplier in the multiplier datapath. Control FSM and datapath live in one module.

---
 rtl/seq_mult_param.sv | 112 +++++++++++
 tb/tb_seq_mult_param.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier: one partial product per clock, fixed WIDTH+2 cycle
// turnaround, optional two's-complement operands handled by sign-magnitude conversion.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic               sys_clk,
  input  logic               nsys_rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   product_q, product_d;
  logic            done_q, done_d;
  logic [WIDTH-1:0] abs_a, abs_b;

  // The most-negative operand maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  always_comb begin
    abs_a = (signed_mode && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
    abs_b = (signed_mode && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mag_b_d   = mag_b_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = {{WIDTH{1'b0}}, abs_a};
          mag_b_d = abs_b;
          neg_d   = signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // mcand_q is shifted once per iteration, so it always equals mag_a << counter.
        if (mag_b_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge nsys_rst) begin
    if (!nsys_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mag_b_q   <= mag_b_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == RUN) || (state_q == FIX);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed and sweep bench for seq_mult_param at WIDTH = 8, 4 and 16 sharing one clock and reset.
module tb_seq_mult_param;

  logic clk;
  logic nsys_rst;
  int   cyc;
  int   checks;
  int   errors;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  logic        start4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;

  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;

  seq_mult_param #(.WIDTH(8)) dut8 (
    .sys_clk(clk), .nsys_rst(nsys_rst), .start(start8), .signed_mode(sm8),
    .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  seq_mult_param #(.WIDTH(4)) dut4 (
    .sys_clk(clk), .nsys_rst(nsys_rst), .start(start4), .signed_mode(sm4),
    .op_a(a4), .op_b(b4), .busy(busy4), .done(done4), .product(prod4)
  );

  seq_mult_param #(.WIDTH(16)) dut16 (
    .sys_clk(clk), .nsys_rst(nsys_rst), .start(start16), .signed_mode(sm16),
    .op_a(a16), .op_b(b16), .busy(busy16), .done(done16), .product(prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference: sign-extend in 64-bit arithmetic and mask to 2*w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic sm);
    longint sa, sb, p, mask;
    sa = longint'(a) & ((64'sd1 <<< w) - 1);
    sb = longint'(b) & ((64'sd1 <<< w) - 1);
    if (sm && a[w-1]) sa = sa - (64'sd1 <<< w);
    if (sm && b[w-1]) sb = sb - (64'sd1 <<< w);
    p    = sa * sb;
    mask = (64'sd1 <<< (2 * w)) - 1;
    return 32'(p & mask);
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      4:       return done4;
      16:      return done16;
      default: return done8;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      4:       return busy4;
      16:      return busy16;
      default: return busy8;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int w);
    case (w)
      4:       return {24'd0, prod4};
      16:      return prod16;
      default: return {16'd0, prod8};
    endcase
  endfunction

  task automatic drive(input int w, input logic st, input logic [15:0] a,
                       input logic [15:0] b, input logic sm);
    case (w)
      4:       begin start4 = st;  a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; end
      16:      begin start16 = st; a16 = a;     b16 = b;     sm16 = sm; end
      default: begin start8 = st;  a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; end
    endcase
  endtask

  // Runs one operation; lat counts edges from acceptance to the edge that raises done (-1 on timeout).
  task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic sm,
                       output logic [31:0] prod, output int lat, output logic overlap);
    @(negedge clk);
    drive(w, 1'b1, a, b, sm);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, a, b, sm);
    lat     = -1;
    overlap = 1'b0;
    prod    = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_done(w) && get_busy(w)) overlap = 1'b1;
      if (get_done(w)) begin
        lat  = n;
        prod = get_prod(w);
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] p;
    int          lat;
    logic        ov;
    nsys_rst = 1'b1;
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    drive(4, 1'b0, 16'd0, 16'd0, 1'b0);
    drive(16, 1'b0, 16'd0, 16'd0, 1'b0);
    #2 nsys_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start8 = ~start8;
      a8 = 8'd13;
      b8 = 8'd11;
    end
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy8); end
    checks++;
    if (done8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done8); end
    checks++;
    if (prod8 !== 16'd0) begin errors++; $display("[TB] FAIL reset_product: got %0d want 0", prod8); end
    start8   = 1'b0;
    nsys_rst = 1'b1;
    @(negedge clk);
    do_op(8, 16'd13, 16'd11, 1'b0, p, lat, ov);
    checks++;
    if (p !== 32'd143) begin errors++; $display("[TB] FAIL first_product: got %0d want 143", p); end
    checks++;
    if (lat !== 9) begin errors++; $display("[TB] FAIL first_latency: got %0d want 9", lat); end
    checks++;
    if (ov !== 1'b0) begin errors++; $display("[TB] FAIL first_busy_done_overlap: got %b want 0", ov); end
  endtask

  task automatic test_corners();
    logic [31:0] p;
    int          lat;
    logic        ov;
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vs [4];
    logic [31:0] ve [4];
    va = '{16'h0080, 16'h0080, 16'h00FF, 16'h00FF};
    vb = '{16'h0080, 16'h007F, 16'h0001, 16'h00FF};
    vs = '{1'b1, 1'b1, 1'b1, 1'b0};
    ve = '{32'h4000, 32'hC080, 32'hFFFF, 32'hFE01};
    for (int i = 0; i < 4; i++) begin
      do_op(8, va[i], vb[i], vs[i], p, lat, ov);
      checks++;
      if (p !== ve[i] || lat !== 9 || ov !== 1'b0) begin
        errors++;
        $display("[TB] FAIL corner_%0d: got product %h latency %0d overlap %b want %h 9 0",
                 i, p, lat, ov, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    t1 = -1;
    t2 = -1;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd5; b8 = 8'd6; sm8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin t1 = cyc; break; end
    end
    checks++;
    if (t1 < 0 || prod8 !== 16'd30) begin
      errors++; $display("[TB] FAIL b2b_first: got product %0d done_seen %0d want 30", prod8, t1);
    end
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd9;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b1 || prod8 !== 16'd30) begin
      errors++;
      $display("[TB] FAIL b2b_hold: got done %b busy %b product %0d want 0 1 30", done8, busy8, prod8);
    end
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd100; sm8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'd200;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin t2 = cyc; break; end
    end
    sm8 = 1'b0;
    checks++;
    if (t2 < 0 || prod8 !== 16'd63) begin
      errors++; $display("[TB] FAIL b2b_second: got product %0d done_seen %0d want 63", prod8, t2);
    end
    checks++;
    if (t2 - t1 !== 10) begin
      errors++; $display("[TB] FAIL b2b_spacing: got %0d cycles want 10", t2 - t1);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] p;
    int          lat;
    logic        ov, saw;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd3; sm8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 nsys_rst = 1'b0;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got busy %b done %b product %0d want 0 0 0", busy8, done8, prod8);
    end
    @(negedge clk);
    nsys_rst = 1'b1;
    saw = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done8 || busy8) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("[TB] FAIL midrun_no_done: got activity %b want 0", saw); end
    do_op(8, 16'd2, 16'd3, 1'b0, p, lat, ov);
    checks++;
    if (p !== 32'd6 || lat !== 9) begin
      errors++; $display("[TB] FAIL midrun_fresh: got product %0d latency %0d want 6 9", p, lat);
    end
  endtask

  task automatic test_sweep_w4();
    logic [31:0] p, e;
    int          lat;
    logic        ov;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          do_op(4, 16'(a), 16'(b), s[0], p, lat, ov);
          e = ref_mul(4, 16'(a), 16'(b), s[0]);
          checks++;
          if (p !== e || lat !== 5 || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL w4_s%0d_%0dx%0d: got %h latency %0d overlap %b want %h 5 0",
                     s, a, b, p, lat, ov, e);
          end
        end
      end
    end
  endtask

  task automatic test_sweep_w16();
    logic [31:0] p, e;
    logic [15:0] a, b;
    int          lat;
    logic        ov, sm;
    do_op(16, 16'h8000, 16'h8000, 1'b1, p, lat, ov);
    checks++;
    if (p !== 32'h4000_0000 || lat !== 17) begin
      errors++; $display("[TB] FAIL w16_minneg: got %h latency %0d want 40000000 17", p, lat);
    end
    for (int i = 0; i < 1000; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      sm = i[0];
      do_op(16, a, b, sm, p, lat, ov);
      e = ref_mul(16, a, b, sm);
      checks++;
      if (p !== e || lat !== 17 || ov !== 1'b0) begin
        errors++;
        $display("[TB] FAIL w16_rand_%0d: %h x %h s%b got %h latency %0d want %h 17",
                 i, a, b, sm, p, lat, e);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_corners();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep_w4();
    test_sweep_w16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
